// File: rtl/w80386dx_pkg.sv
// Shared constants and types for the prefetch/instruction queue.
package w80386dx_pkg;

    localparam int unsigned QUEUE_DEPTH  = 32;
    localparam int unsigned WINDOW_BYTES = 16;
    localparam int unsigned FETCH_BYTES  = 4;

    typedef enum logic {
        RUN  = 1'b0,
        SKIP = 1'b1
    } iq_state_t;

endpackage

// File: rtl/instruction_queue_window.sv
// Rotates the circular byte buffer into the decode window, masking bytes beyond count.
module instruction_queue_window #(
    parameter int unsigned QUEUE_DEPTH  = 32,
    parameter int unsigned WINDOW_BYTES = 16
) (
    input  logic [7:0]                          mem [QUEUE_DEPTH],
    input  logic [$clog2(QUEUE_DEPTH)-1:0]      rd_ptr,
    input  logic [$clog2(QUEUE_DEPTH):0]        count,
    output logic [7:0]                          instruction [0:WINDOW_BYTES-1],
    output logic [$clog2(WINDOW_BYTES+1)-1:0]   bytes_available
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AV_W  = $clog2(WINDOW_BYTES + 1);

    always_comb begin
        bytes_available = (count >= CNT_W'(WINDOW_BYTES)) ? AV_W'(WINDOW_BYTES) : AV_W'(count);
        for (int k = 0; k < WINDOW_BYTES; k++) begin
            instruction[k] = (CNT_W'(k) < count) ? mem[rd_ptr + PTR_W'(k)] : 8'h00;
        end
    end

endmodule

// File: rtl/instruction_queue.sv
// Byte-granular prefetch queue: dword fills from the bus unit, variable-length
// consumes from decode, flush with a skip of the leading bytes of the target dword.
module instruction_queue #(
    parameter int unsigned QUEUE_DEPTH  = w80386dx_pkg::QUEUE_DEPTH,
    parameter int unsigned WINDOW_BYTES = w80386dx_pkg::WINDOW_BYTES
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                i_flush,
    input  logic [1:0]                          i_flush_offset,
    input  logic                                i_fetch_valid,
    input  logic [31:0]                         i_fetch_data,
    output logic                                o_fetch_ready,
    output logic [7:0]                          o_instruction [0:WINDOW_BYTES-1],
    output logic [$clog2(WINDOW_BYTES+1)-1:0]   o_bytes_available,
    input  logic                                i_consume_valid,
    input  logic [3:0]                          i_consume_bytes,
    output logic                                o_empty,
    output logic                                o_error
);

    import w80386dx_pkg::*;

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OFF_W = $clog2(FETCH_BYTES);

    logic [7:0]       mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    iq_state_t        state_q, state_d;
    logic [OFF_W-1:0] skip_off_q, skip_off_d;
    logic             error_q, error_d;

    logic             fetch_acc;
    logic             consume_ok;
    logic [OFF_W-1:0] wr_first;
    logic [CNT_W-1:0] wr_bytes;

    // Ready depends on registered count only, so it never sees same-cycle consume/flush.
    assign o_fetch_ready = (count_q <= CNT_W'(QUEUE_DEPTH - FETCH_BYTES));
    assign fetch_acc     = i_fetch_valid && o_fetch_ready && !i_flush;
    assign consume_ok    = i_consume_valid && (i_consume_bytes != 4'd0)
                           && (CNT_W'(i_consume_bytes) <= count_q);
    assign wr_first      = (state_q == SKIP) ? skip_off_q : '0;
    assign wr_bytes      = fetch_acc ? (CNT_W'(FETCH_BYTES) - CNT_W'(wr_first)) : '0;

    always_comb begin
        state_d    = state_q;
        skip_off_d = skip_off_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        error_d    = 1'b0;
        if (i_flush) begin
            state_d    = (i_flush_offset != 2'd0) ? SKIP : RUN;
            skip_off_d = OFF_W'(i_flush_offset);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fetch_acc) begin
                state_d  = RUN;
                wr_ptr_d = wr_ptr_q + PTR_W'(wr_bytes);
            end
            if (consume_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(i_consume_bytes);
            end
            count_d = count_q + wr_bytes - (consume_ok ? CNT_W'(i_consume_bytes) : CNT_W'(0));
            error_d = i_consume_valid && !consume_ok;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= RUN;
            skip_off_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_off_q <= skip_off_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            error_q    <= error_d;
        end
    end

    // Byte lanes below the skip offset are dropped; the rest pack from wr_ptr upward.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < FETCH_BYTES; b++) begin
            if (fetch_acc && (OFF_W'(b) >= wr_first)) begin
                mem_q[wr_ptr_q + PTR_W'(OFF_W'(b) - wr_first)] <= i_fetch_data[8*b +: 8];
            end
        end
    end

    instruction_queue_window #(
        .QUEUE_DEPTH  (QUEUE_DEPTH),
        .WINDOW_BYTES (WINDOW_BYTES)
    ) u_window (
        .mem             (mem_q),
        .rd_ptr          (rd_ptr_q),
        .count           (count_q),
        .instruction     (o_instruction),
        .bytes_available (o_bytes_available)
    );

    assign o_empty = (count_q == '0);
    assign o_error = error_q;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed and model-checked bench for instruction_queue.
module tb_instruction_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] flush_offset = 2'd0;
    logic       fetch_valid = 1'b0;
    logic [31:0] fetch_data = 32'h0;
    logic       fetch_ready;
    logic [7:0] instr [0:15];
    logic [4:0] avail;
    logic       consume_valid = 1'b0;
    logic [3:0] consume_bytes = 4'd0;
    logic       empty;
    logic       error;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instruction_queue dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_flush           (flush),
        .i_flush_offset    (flush_offset),
        .i_fetch_valid     (fetch_valid),
        .i_fetch_data      (fetch_data),
        .o_fetch_ready     (fetch_ready),
        .o_instruction     (instr),
        .o_bytes_available (avail),
        .i_consume_valid   (consume_valid),
        .i_consume_bytes   (consume_bytes),
        .o_empty           (empty),
        .o_error           (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; fetch_valid = 1'b0; consume_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        fetch_valid = 1'b1; fetch_data = d;
        tick();
        idle();
    endtask

    task automatic consume(input logic [3:0] n);
        consume_valid = 1'b1; consume_bytes = n;
        tick();
        idle();
    endtask

    task automatic do_flush(input logic [1:0] off);
        flush = 1'b1; flush_offset = off;
        tick();
        idle();
    endtask

    task automatic test_reset();
        logic [127:0] w;
        rst_n = 1'b0;
        idle();
        #3;
        for (int k = 0; k < 16; k++) w[8*k +: 8] = instr[k];
        n_checks++; if (avail !== 5'd0) $display("FAIL reset_avail got %0d want 0", avail); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else n_pass++;
        n_checks++; if (fetch_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", fetch_ready); else n_pass++;
        n_checks++; if (w !== 128'h0) $display("FAIL reset_window got %h want 0", w); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_window();
        logic [127:0] w, e;
        push(32'h03020100);
        n_checks++; if (avail !== 5'd4) $display("FAIL first_fill_avail got %0d want 4", avail); else n_pass++;
        push(32'h07060504);
        push(32'h0B0A0908);
        push(32'h0F0E0D0C);
        for (int k = 0; k < 16; k++) begin
            w[8*k +: 8] = instr[k];
            e[8*k +: 8] = 8'(k);
        end
        n_checks++; if (avail !== 5'd16) $display("FAIL fill16_avail got %0d want 16", avail); else n_pass++;
        n_checks++; if (w !== e) $display("FAIL fill16_window got %h want %h", w, e); else n_pass++;
        n_checks++; if (empty !== 1'b0) $display("FAIL fill16_empty got %b want 0", empty); else n_pass++;
    endtask

    task automatic test_full_and_wrap();
        push(32'h13121110);
        push(32'h17161514);
        push(32'h1B1A1918);
        n_checks++; if (fetch_ready !== 1'b1) $display("FAIL ready_at_28 got %b want 1", fetch_ready); else n_pass++;
        push(32'h1F1E1D1C);
        n_checks++; if (fetch_ready !== 1'b0) $display("FAIL ready_at_32 got %b want 0", fetch_ready); else n_pass++;
        push(32'hEEEEEEEE);
        n_checks++; if (fetch_ready !== 1'b0) $display("FAIL full_stays_full got %b want 0", fetch_ready); else n_pass++;
        consume(4'd4);
        n_checks++; if (fetch_ready !== 1'b1) $display("FAIL ready_after_consume got %b want 1", fetch_ready); else n_pass++;
        n_checks++; if (instr[0] !== 8'h04) $display("FAIL consume4_head got %h want 04", instr[0]); else n_pass++;
        push(32'h23222120);
        consume(4'd15);
        n_checks++; if (instr[0] !== 8'h13) $display("FAIL wrap_head got %h want 13", instr[0]); else n_pass++;
        n_checks++; if (instr[12] !== 8'h1F) $display("FAIL wrap_b12 got %h want 1f", instr[12]); else n_pass++;
        n_checks++; if (instr[13] !== 8'h20) $display("FAIL wrap_b13 got %h want 20", instr[13]); else n_pass++;
        n_checks++; if (instr[15] !== 8'h22) $display("FAIL wrap_b15 got %h want 22", instr[15]); else n_pass++;
        consume(4'd15);
        n_checks++; if (avail !== 5'd2) $display("FAIL tail_avail got %0d want 2", avail); else n_pass++;
        n_checks++; if ({instr[0], instr[1], instr[2]} !== 24'h222300)
            $display("FAIL tail_window got %h%h%h want 222300", instr[0], instr[1], instr[2]); else n_pass++;
    endtask

    task automatic test_flush_skip();
        flush = 1'b1; flush_offset = 2'd3;
        fetch_valid = 1'b1; fetch_data = 32'h11111111;
        consume_valid = 1'b1; consume_bytes = 4'd9;
        tick();
        idle();
        n_checks++; if (empty !== 1'b1) $display("FAIL flush_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (avail !== 5'd0) $display("FAIL flush_avail got %0d want 0", avail); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL flush_no_error got %b want 0", error); else n_pass++;
        push(32'hDDCCBBAA);
        n_checks++; if (avail !== 5'd1) $display("FAIL skip_avail got %0d want 1", avail); else n_pass++;
        n_checks++; if (instr[0] !== 8'hDD) $display("FAIL skip_head got %h want dd", instr[0]); else n_pass++;
        push(32'h44332211);
        n_checks++; if (avail !== 5'd5) $display("FAIL after_skip_avail got %0d want 5", avail); else n_pass++;
        n_checks++; if ({instr[1], instr[4]} !== 16'h1144)
            $display("FAIL after_skip_bytes got %h%h want 1144", instr[1], instr[4]); else n_pass++;
    endtask

    task automatic test_illegal_consume();
        consume(4'd7);
        n_checks++; if (error !== 1'b1) $display("FAIL over_consume_error got %b want 1", error); else n_pass++;
        n_checks++; if (avail !== 5'd5) $display("FAIL over_consume_avail got %0d want 5", avail); else n_pass++;
        n_checks++; if (instr[0] !== 8'hDD) $display("FAIL over_consume_head got %h want dd", instr[0]); else n_pass++;
        tick();
        n_checks++; if (error !== 1'b0) $display("FAIL error_one_cycle got %b want 0", error); else n_pass++;
        consume(4'd0);
        n_checks++; if (error !== 1'b1) $display("FAIL zero_consume_error got %b want 1", error); else n_pass++;
        consume(4'd5);
        n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (avail !== 5'd0) $display("FAIL drain_avail got %0d want 0", avail); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL drain_error got %b want 0", error); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_flush(2'd2);
        push(32'h0100EEEE);
        push(32'h05040302);
        push(32'h09080706);
        n_checks++; if (avail !== 5'd10) $display("FAIL b2b_pre_avail got %0d want 10", avail); else n_pass++;
        fetch_valid = 1'b1; fetch_data = 32'h0D0C0B0A;
        consume_valid = 1'b1; consume_bytes = 4'd3;
        tick();
        idle();
        n_checks++; if (avail !== 5'd11) $display("FAIL b2b_avail got %0d want 11", avail); else n_pass++;
        n_checks++; if ({instr[0], instr[10], instr[11]} !== 24'h030D00)
            $display("FAIL b2b_window got %h%h%h want 030d00", instr[0], instr[10], instr[11]); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0]   mq [$];
        logic         skip_pend;
        logic [1:0]   skip_off;
        logic         exp_err;
        logic         m_ready;
        logic         legal;
        logic [127:0] w, e;
        int           first;
        mq.delete();
        skip_pend = 1'b0; skip_off = 2'd0; exp_err = 1'b0;
        do_flush(2'd0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush         = ($urandom_range(0, 63) == 0);
            flush_offset  = 2'($urandom_range(0, 3));
            fetch_valid   = ($urandom_range(0, 9) < 7);
            fetch_data    = $urandom;
            consume_valid = ($urandom_range(0, 1) == 1);
            consume_bytes = 4'($urandom_range(0, 15));
            m_ready = (mq.size() <= 28);
            legal   = consume_valid && (consume_bytes != 0) && (int'(consume_bytes) <= mq.size());
            tick();
            if (flush) begin
                mq.delete();
                skip_pend = (flush_offset != 2'd0);
                skip_off  = flush_offset;
                exp_err   = 1'b0;
            end else begin
                exp_err = consume_valid && !legal;
                if (legal) for (int i = 0; i < int'(consume_bytes); i++) void'(mq.pop_front());
                if (fetch_valid && m_ready) begin
                    first = skip_pend ? int'(skip_off) : 0;
                    for (int b = first; b < 4; b++) mq.push_back(fetch_data[8*b +: 8]);
                    skip_pend = 1'b0;
                end
            end
            idle();
            for (int k = 0; k < 16; k++) begin
                w[8*k +: 8] = instr[k];
                e[8*k +: 8] = (k < mq.size()) ? mq[k] : 8'h00;
            end
            n_checks++; if (w !== e) $display("FAIL rnd_window cyc %0d got %h want %h", cyc, w, e); else n_pass++;
            n_checks++; if (avail !== 5'((mq.size() > 16) ? 16 : mq.size()))
                $display("FAIL rnd_avail cyc %0d got %0d want size %0d", cyc, avail, mq.size()); else n_pass++;
            n_checks++; if ({fetch_ready, empty, error} !== {(mq.size() <= 28), (mq.size() == 0), exp_err})
                $display("FAIL rnd_flags cyc %0d got %b%b%b want %b%b%b", cyc, fetch_ready, empty, error,
                         (mq.size() <= 28), (mq.size() == 0), exp_err); else n_pass++;
            if (cyc == 1500) begin
                rst_n = 1'b0;
                #2;
                for (int k = 0; k < 16; k++) w[8*k +: 8] = instr[k];
                n_checks++; if ({avail, empty, error, fetch_ready} !== {5'd0, 1'b1, 1'b0, 1'b1})
                    $display("FAIL midrun_reset_flags got %0d %b %b %b want 0 1 0 1", avail, empty, error, fetch_ready);
                else n_pass++;
                n_checks++; if (w !== 128'h0) $display("FAIL midrun_reset_window got %h want 0", w); else n_pass++;
                @(negedge clk);
                rst_n = 1'b1;
                mq.delete();
                skip_pend = 1'b0; exp_err = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_window();
        test_full_and_wrap();
        test_flush_skip();
        test_illegal_consume();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
